avalon_tx: RTL and testbench

AVALON_TX -- requirements
Module: avalon_tx

---
 rtl/avalon_tx_pkg.sv | 36 +++
 rtl/tx_skid_buf.sv | 58 +++++
 rtl/avalon_tx.sv | 172 +++++++++++++++++
 tb/tb_avalon_tx.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_tx_pkg.sv
// avalon_tx_pkg
//   Shared definitions for the Avalon-ST transmit arbiter: source indices,
//   arbiter state encoding and the round-robin pick helper.
package avalon_tx_pkg;

    localparam logic [1:0] SRC_RW = 2'd0;
    localparam logic [1:0] SRC_RR = 2'd1;
    localparam logic [1:0] SRC_CC = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Successor in the fixed rotation rw -> rr -> cc -> rw.
    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s == SRC_CC) ? SRC_RW : s + 2'd1;
    endfunction

    // First requester found after 'last' in rotation order.
    // Caller guarantees at least one request bit is set.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] c0;
        logic [1:0] c1;
        logic [1:0] c2;
        logic [1:0] pick;
        c0 = next_src(last);
        c1 = next_src(c0);
        c2 = next_src(c1);
        if (req[c0])      pick = c0;
        else if (req[c1]) pick = c1;
        else              pick = c2;
        return pick;
    endfunction

endpackage

// File: rtl/tx_skid_buf.sv
// tx_skid_buf
//   Two-entry skid buffer with registered outputs.
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     in_data / in_push    write side; push is ignored while full
//     full                 both entries occupied
//     out_data / out_valid head entry, registered
//     out_ready            consumer accepts the head this cycle
module tx_skid_buf #(
    parameter int unsigned WIDTH = 131
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_push,
    output logic             full,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] skid;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign full      = (count == 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = head;
    assign push      = in_push && !full;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            skid  <= '0;
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= in_data;
                    else               skid <= in_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) head <= skid;
                    count <= count - 2'd1;
                end
                // Push is gated by full and pop needs a valid head, so a
                // simultaneous push/pop only happens with one entry held.
                2'b11: head <= in_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/avalon_tx.sv
// avalon_tx
//   Round-robin arbiter merging three AXI-Stream TLP sources (DMA write
//   requests, DMA read requests, host-read completions) onto one Avalon-ST
//   transmit interface with ready latency 0.
//   Ports:
//     trn_clk, trn_rst_n      clock, asynchronous active-low reset
//     s_axis_rw_*             DMA write-request source
//     s_axis_rr_*             DMA read-request source
//     s_axis_cc_*             host-read completion source
//     tx_st_data0             TLP data
//     tx_st_sop0/eop0         first / last word of a TLP
//     tx_st_empty0            upper half of the eop word is invalid
//     tx_st_valid0/ready0     Avalon-ST handshake
module avalon_tx
    import avalon_tx_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 128,
    parameter int unsigned BE_WIDTH       = AXI_DATA_WIDTH / 8
) (
    input  logic                      trn_clk,
    input  logic                      trn_rst_n,

    input  logic [AXI_DATA_WIDTH-1:0] s_axis_rw_tdata,
    input  logic [BE_WIDTH-1:0]       s_axis_rw_tstrb,
    input  logic                      s_axis_rw_tlast,
    input  logic                      s_axis_rw_tvalid,
    output logic                      s_axis_rw_tready,

    input  logic [AXI_DATA_WIDTH-1:0] s_axis_rr_tdata,
    input  logic [BE_WIDTH-1:0]       s_axis_rr_tstrb,
    input  logic                      s_axis_rr_tlast,
    input  logic                      s_axis_rr_tvalid,
    output logic                      s_axis_rr_tready,

    input  logic [AXI_DATA_WIDTH-1:0] s_axis_cc_tdata,
    input  logic [BE_WIDTH-1:0]       s_axis_cc_tstrb,
    input  logic                      s_axis_cc_tlast,
    input  logic                      s_axis_cc_tvalid,
    output logic                      s_axis_cc_tready,

    output logic [AXI_DATA_WIDTH-1:0] tx_st_data0,
    output logic                      tx_st_sop0,
    output logic                      tx_st_eop0,
    output logic                      tx_st_empty0,
    output logic                      tx_st_valid0,
    input  logic                      tx_st_ready0
);

    localparam int unsigned HALF_BE   = BE_WIDTH / 2;
    localparam int unsigned PAYLOAD_W = AXI_DATA_WIDTH + 3;

    arb_state_t state;
    logic [1:0] grant;
    logic [1:0] last_grant;
    logic       first;

    logic [2:0] req;
    logic [2:0] other_req;
    logic       xfer;
    logic       accept;
    logic       buf_full;
    logic       buf_valid;

    logic [AXI_DATA_WIDTH-1:0]   sel_data;
    logic [BE_WIDTH-HALF_BE-1:0] sel_strb_hi;
    logic                        sel_last;
    logic                        sel_valid;
    logic [PAYLOAD_W-1:0]        payload;
    logic [PAYLOAD_W-1:0]        buf_data;

    // Lower strobe lanes carry no information for the Avalon side.
    logic strb_lo_unused;
    assign strb_lo_unused = ^{s_axis_rw_tstrb[HALF_BE-1:0],
                              s_axis_rr_tstrb[HALF_BE-1:0],
                              s_axis_cc_tstrb[HALF_BE-1:0]};

    assign req       = {s_axis_cc_tvalid, s_axis_rr_tvalid, s_axis_rw_tvalid};
    assign other_req = req & ~(3'b001 << grant);
    assign xfer      = (state == XFER);

    always_comb begin
        sel_data    = '0;
        sel_strb_hi = '0;
        sel_last    = 1'b0;
        sel_valid   = 1'b0;
        case (grant)
            SRC_RW: begin
                sel_data    = s_axis_rw_tdata;
                sel_strb_hi = s_axis_rw_tstrb[BE_WIDTH-1:HALF_BE];
                sel_last    = s_axis_rw_tlast;
                sel_valid   = s_axis_rw_tvalid;
            end
            SRC_RR: begin
                sel_data    = s_axis_rr_tdata;
                sel_strb_hi = s_axis_rr_tstrb[BE_WIDTH-1:HALF_BE];
                sel_last    = s_axis_rr_tlast;
                sel_valid   = s_axis_rr_tvalid;
            end
            SRC_CC: begin
                sel_data    = s_axis_cc_tdata;
                sel_strb_hi = s_axis_cc_tstrb[BE_WIDTH-1:HALF_BE];
                sel_last    = s_axis_cc_tlast;
                sel_valid   = s_axis_cc_tvalid;
            end
            default: ;
        endcase
    end

    assign s_axis_rw_tready = xfer && (grant == SRC_RW) && !buf_full;
    assign s_axis_rr_tready = xfer && (grant == SRC_RR) && !buf_full;
    assign s_axis_cc_tready = xfer && (grant == SRC_CC) && !buf_full;
    assign accept           = xfer && sel_valid && !buf_full;

    assign payload = {first, sel_last, sel_last && (sel_strb_hi == '0), sel_data};

    always_ff @(posedge trn_clk or negedge trn_rst_n) begin
        if (!trn_rst_n) begin
            state      <= IDLE;
            grant      <= SRC_RW;
            last_grant <= SRC_CC;
            first      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant <= rr_pick(req, last_grant);
                        first <= 1'b1;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (accept) begin
                        first <= 1'b0;
                        if (sel_last) begin
                            last_grant <= grant;
                            // Hand straight to the next waiting source so
                            // back-to-back packets leave no bubble; IDLE is
                            // only revisited when nobody else is requesting.
                            if (|other_req) begin
                                grant <= rr_pick(other_req, grant);
                                first <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    tx_skid_buf #(
        .WIDTH(PAYLOAD_W)
    ) u_skid (
        .clk      (trn_clk),
        .rst_n    (trn_rst_n),
        .in_data  (payload),
        .in_push  (accept),
        .full     (buf_full),
        .out_data (buf_data),
        .out_valid(buf_valid),
        .out_ready(tx_st_ready0)
    );

    assign tx_st_valid0 = buf_valid;
    assign tx_st_data0  = buf_data[AXI_DATA_WIDTH-1:0];
    assign tx_st_sop0   = buf_valid && buf_data[PAYLOAD_W-1];
    assign tx_st_eop0   = buf_valid && buf_data[PAYLOAD_W-2];
    assign tx_st_empty0 = buf_valid && buf_data[PAYLOAD_W-3];

endmodule

// File: tb/tb_avalon_tx.sv
module tb_avalon_tx;

    localparam int unsigned DW = 128;
    localparam int unsigned BW = DW / 8;

    typedef struct {
        logic [DW-1:0] d;
        logic [BW-1:0] s;
        logic          l;
        logic          f;
    } word_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
        logic          empty;
        int            cyc;
    } out_t;

    logic          trn_clk   = 1'b0;
    logic          trn_rst_n = 1'b1;
    logic [DW-1:0] tdata  [3];
    logic [BW-1:0] tstrb  [3];
    logic          tlast  [3];
    logic          tvalid [3];
    logic          rw_tready, rr_tready, cc_tready;
    logic [DW-1:0] tx_st_data0;
    logic          tx_st_sop0, tx_st_eop0, tx_st_empty0, tx_st_valid0;
    logic          tx_st_ready0 = 1'b0;

    word_t       srcq [3][$];
    word_t       expq [3][$];
    out_t        out_q[$];
    bit          acc  [3];
    bit          gate [3];
    int unsigned vpct       = 100;
    bit          rand_ready = 1'b0;
    int          cyc        = 0;
    int          n_checks   = 0;
    int          n_pass     = 0;

    avalon_tx #(
        .AXI_DATA_WIDTH(DW),
        .BE_WIDTH(BW)
    ) dut (
        .trn_clk         (trn_clk),
        .trn_rst_n       (trn_rst_n),
        .s_axis_rw_tdata (tdata[0]),
        .s_axis_rw_tstrb (tstrb[0]),
        .s_axis_rw_tlast (tlast[0]),
        .s_axis_rw_tvalid(tvalid[0]),
        .s_axis_rw_tready(rw_tready),
        .s_axis_rr_tdata (tdata[1]),
        .s_axis_rr_tstrb (tstrb[1]),
        .s_axis_rr_tlast (tlast[1]),
        .s_axis_rr_tvalid(tvalid[1]),
        .s_axis_rr_tready(rr_tready),
        .s_axis_cc_tdata (tdata[2]),
        .s_axis_cc_tstrb (tstrb[2]),
        .s_axis_cc_tlast (tlast[2]),
        .s_axis_cc_tvalid(tvalid[2]),
        .s_axis_cc_tready(cc_tready),
        .tx_st_data0     (tx_st_data0),
        .tx_st_sop0      (tx_st_sop0),
        .tx_st_eop0      (tx_st_eop0),
        .tx_st_empty0    (tx_st_empty0),
        .tx_st_valid0    (tx_st_valid0),
        .tx_st_ready0    (tx_st_ready0)
    );

    initial forever #5 trn_clk = ~trn_clk;

    // Data word tagged with source in the top two bits, packet and word index.
    function automatic logic [DW-1:0] mkd(input int unsigned s, input int unsigned p, input int unsigned w);
        return {s[1:0], 30'h0ACE1234, p, w, ~w};
    endfunction

    task automatic step();
        @(posedge trn_clk);
        #1;
    endtask

    task automatic push_pkt(input int unsigned s, input int unsigned p, input int unsigned len,
                            input logic [BW-1:0] strb);
        word_t w;
        for (int unsigned i = 0; i < len; i++) begin
            w.d = mkd(s, p, i);
            w.s = strb;
            w.l = (i == len - 1);
            w.f = (i == 0);
            srcq[s].push_back(w);
            expq[s].push_back(w);
        end
    endtask

    task automatic wait_out(input int n, input int budget);
        for (int i = 0; i < budget && out_q.size() < n; i++) step();
    endtask

    // Source drivers: present queue heads, retire words accepted at the last edge.
    initial begin
        word_t tmp;
        for (int s = 0; s < 3; s++) begin
            tdata[s] = '0; tstrb[s] = '0; tlast[s] = 1'b0; tvalid[s] = 1'b0;
        end
        forever begin
            @(posedge trn_clk);
            #2;
            for (int s = 0; s < 3; s++) begin
                if (acc[s] && srcq[s].size() > 0) tmp = srcq[s].pop_front();
                acc[s] = 1'b0;
                if (srcq[s].size() > 0) begin
                    tdata[s]  = srcq[s][0].d;
                    tstrb[s]  = srcq[s][0].s;
                    tlast[s]  = srcq[s][0].l;
                    tvalid[s] = !gate[s] && ($urandom_range(99) < vpct);
                end else begin
                    tdata[s] = '0; tstrb[s] = '0; tlast[s] = 1'b0; tvalid[s] = 1'b0;
                end
            end
            if (rand_ready) tx_st_ready0 = ($urandom_range(99) < 85);
        end
    end

    // Monitor: record source handshakes and output transfers.
    initial forever begin
        logic [2:0] rdy;
        @(negedge trn_clk);
        cyc++;
        rdy = {cc_tready, rr_tready, rw_tready};
        for (int s = 0; s < 3; s++)
            if (tvalid[s] === 1'b1 && rdy[s] === 1'b1) acc[s] = 1'b1;
        if (tx_st_valid0 === 1'b1 && tx_st_ready0 === 1'b1)
            out_q.push_back('{tx_st_data0, tx_st_sop0, tx_st_eop0, tx_st_empty0, cyc});
    end

    task automatic test_reset();
        trn_rst_n = 1'b1;
        #2 trn_rst_n = 1'b0;
        #1;
        n_checks++; if (tx_st_valid0 !== 1'b0) $display("FAIL reset_valid got %b want 0", tx_st_valid0); else n_pass++;
        n_checks++; if (tx_st_sop0 !== 1'b0) $display("FAIL reset_sop got %b want 0", tx_st_sop0); else n_pass++;
        n_checks++; if (tx_st_eop0 !== 1'b0) $display("FAIL reset_eop got %b want 0", tx_st_eop0); else n_pass++;
        n_checks++; if (tx_st_empty0 !== 1'b0) $display("FAIL reset_empty got %b want 0", tx_st_empty0); else n_pass++;
        n_checks++; if (tx_st_data0 !== '0) $display("FAIL reset_data got %h want 0", tx_st_data0); else n_pass++;
        n_checks++; if ({rw_tready, rr_tready, cc_tready} !== 3'b000)
            $display("FAIL reset_tready got %b want 000", {rw_tready, rr_tready, cc_tready}); else n_pass++;
        @(posedge trn_clk);
        @(posedge trn_clk);
        #3 trn_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if ({rw_tready, rr_tready, cc_tready, tx_st_valid0} !== 4'b0000)
                $display("FAIL idle_quiet got %b want 0000", {rw_tready, rr_tready, cc_tready, tx_st_valid0}); else n_pass++;
        end
    endtask

    task automatic test_rr_order();
        out_q.delete();
        tx_st_ready0 = 1'b1;
        push_pkt(0, 1, 2, '1);
        push_pkt(1, 1, 2, '1);
        push_pkt(2, 1, 2, '1);
        wait_out(6, 40);
        repeat (3) step();
        n_checks++; if (out_q.size() != 6) $display("FAIL rr_count got %0d want 6", out_q.size()); else n_pass++;
        for (int i = 0; i < out_q.size() && i < 6; i++) begin
            n_checks++; if (out_q[i].d !== mkd(i / 2, 1, i % 2))
                $display("FAIL rr_data[%0d] got %h want %h", i, out_q[i].d, mkd(i / 2, 1, i % 2)); else n_pass++;
            n_checks++; if ({out_q[i].sop, out_q[i].eop, out_q[i].empty} !== {i % 2 == 0, i % 2 == 1, 1'b0})
                $display("FAIL rr_flags[%0d] got %b want %b", i, {out_q[i].sop, out_q[i].eop, out_q[i].empty},
                         {i % 2 == 0, i % 2 == 1, 1'b0}); else n_pass++;
            n_checks++; if (out_q[i].cyc != out_q[0].cyc + i)
                $display("FAIL rr_consecutive[%0d] got cycle %0d want %0d", i, out_q[i].cyc, out_q[0].cyc + i); else n_pass++;
        end
    endtask

    task automatic test_single_empty();
        out_q.delete();
        tx_st_ready0 = 1'b1;
        push_pkt(2, 2, 1, 16'h00FF);
        wait_out(1, 20);
        repeat (3) step();
        n_checks++; if (out_q.size() != 1) $display("FAIL single_count got %0d want 1", out_q.size()); else n_pass++;
        if (out_q.size() > 0) begin
            n_checks++; if (out_q[0].d !== mkd(2, 2, 0))
                $display("FAIL single_data got %h want %h", out_q[0].d, mkd(2, 2, 0)); else n_pass++;
            n_checks++; if ({out_q[0].sop, out_q[0].eop, out_q[0].empty} !== 3'b111)
                $display("FAIL single_flags got %b want 111", {out_q[0].sop, out_q[0].eop, out_q[0].empty}); else n_pass++;
        end
    endtask

    task automatic test_stall();
        bit found;
        out_q.delete();
        tx_st_ready0 = 1'b1;
        push_pkt(0, 3, 4, '1);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge trn_clk);
            if (tx_st_valid0 === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++; if (found !== 1'b1) $display("FAIL stall_start got %b want 1", found); else n_pass++;
        @(posedge trn_clk);
        #1 tx_st_ready0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge trn_clk);
            n_checks++; if ({tx_st_valid0, tx_st_data0} !== {1'b1, mkd(0, 3, 1)})
                $display("FAIL stall_hold[%0d] got %b/%h want 1/%h", k, tx_st_valid0, tx_st_data0, mkd(0, 3, 1)); else n_pass++;
            if (k >= 1) begin
                n_checks++; if (rw_tready !== 1'b0) $display("FAIL stall_tready[%0d] got %b want 0", k, rw_tready); else n_pass++;
            end
        end
        @(posedge trn_clk);
        #1 tx_st_ready0 = 1'b1;
        wait_out(4, 20);
        repeat (3) step();
        n_checks++; if (out_q.size() != 4) $display("FAIL stall_count got %0d want 4", out_q.size()); else n_pass++;
        for (int i = 0; i < out_q.size() && i < 4; i++) begin
            n_checks++; if ({out_q[i].d, out_q[i].sop, out_q[i].eop} !== {mkd(0, 3, i), i == 0, i == 3})
                $display("FAIL stall_word[%0d] got %h/%b%b want %h/%b%b", i, out_q[i].d, out_q[i].sop, out_q[i].eop,
                         mkd(0, 3, i), i == 0, i == 3); else n_pass++;
        end
    endtask

    task automatic test_tvalid_gap();
        int gap_idle;
        int guard;
        out_q.delete();
        tx_st_ready0 = 1'b1;
        push_pkt(0, 4, 4, '1);
        for (int i = 0; i < 20 && srcq[0].size() >= 4; i++) step();
        gate[0] = 1'b1;
        push_pkt(1, 4, 1, '1);
        gap_idle = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge trn_clk);
            n_checks++; if (rr_tready !== 1'b0) $display("FAIL gap_rr_tready[%0d] got %b want 0", i, rr_tready); else n_pass++;
            if (tx_st_valid0 !== 1'b1) gap_idle++;
        end
        n_checks++; if (gap_idle < 2) $display("FAIL gap_idle got %0d want >=2", gap_idle); else n_pass++;
        step();
        gate[0] = 1'b0;
        guard = 0;
        while (srcq[0].size() > 0 && guard < 20) begin
            @(negedge trn_clk);
            n_checks++; if (rr_tready !== 1'b0) $display("FAIL gap_rr_hold[%0d] got %b want 0", guard, rr_tready); else n_pass++;
            @(posedge trn_clk);
            #3;
            guard++;
        end
        wait_out(5, 20);
        repeat (3) step();
        n_checks++; if (out_q.size() != 5) $display("FAIL gap_count got %0d want 5", out_q.size()); else n_pass++;
        for (int i = 0; i < out_q.size() && i < 5; i++) begin
            n_checks++; if ({out_q[i].d, out_q[i].sop, out_q[i].eop} !==
                            {(i < 4) ? mkd(0, 4, i) : mkd(1, 4, 0), i == 0 || i == 4, i >= 3})
                $display("FAIL gap_word[%0d] got %h/%b%b want %h/%b%b", i, out_q[i].d, out_q[i].sop, out_q[i].eop,
                         (i < 4) ? mkd(0, 4, i) : mkd(1, 4, 0), i == 0 || i == 4, i >= 3); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        out_q.delete();
        tx_st_ready0 = 1'b1;
        push_pkt(0, 5, 4, '1);
        wait_out(2, 20);
        #3;
        n_checks++; if (tx_st_valid0 !== 1'b1) $display("FAIL mid_prereset_valid got %b want 1", tx_st_valid0); else n_pass++;
        trn_rst_n = 1'b0;
        #1;
        n_checks++; if ({tx_st_valid0, tx_st_sop0, tx_st_eop0, tx_st_empty0, rw_tready} !== 5'b00000)
            $display("FAIL mid_reset_ctrl got %b want 00000",
                     {tx_st_valid0, tx_st_sop0, tx_st_eop0, tx_st_empty0, rw_tready}); else n_pass++;
        n_checks++; if (tx_st_data0 !== '0) $display("FAIL mid_reset_data got %h want 0", tx_st_data0); else n_pass++;
        for (int s = 0; s < 3; s++) begin
            srcq[s].delete();
            acc[s] = 1'b0;
        end
        out_q.delete();
        @(posedge trn_clk);
        @(posedge trn_clk);
        #3 trn_rst_n = 1'b1;
        push_pkt(1, 6, 2, '1);
        wait_out(2, 20);
        repeat (3) step();
        n_checks++; if (out_q.size() != 2) $display("FAIL mid_after_count got %0d want 2", out_q.size()); else n_pass++;
        if (out_q.size() >= 2) begin
            n_checks++; if ({out_q[0].d, out_q[0].sop, out_q[0].eop} !== {mkd(1, 6, 0), 2'b10})
                $display("FAIL mid_after_first got %h/%b%b want %h/10", out_q[0].d, out_q[0].sop, out_q[0].eop,
                         mkd(1, 6, 0)); else n_pass++;
            n_checks++; if ({out_q[1].d, out_q[1].sop, out_q[1].eop} !== {mkd(1, 6, 1), 2'b01})
                $display("FAIL mid_after_second got %h/%b%b want %h/01", out_q[1].d, out_q[1].sop, out_q[1].eop,
                         mkd(1, 6, 1)); else n_pass++;
        end
    endtask

    task automatic test_random();
        int          total;
        int          seen;
        int          sops;
        int          eops;
        int unsigned src;
        int unsigned cur;
        bit          in_pkt;
        bit          ok;
        out_t        o;
        word_t       e;
        logic [BW-1:0] strb;
        int unsigned len;
        int unsigned s;
        out_q.delete();
        for (int k = 0; k < 3; k++) begin
            expq[k].delete();
            srcq[k].delete();
        end
        total = 0;
        for (int p = 0; p < 10000; p++) begin
            s    = $urandom_range(2);
            len  = $urandom_range(3, 1);
            strb = BW'($urandom);
            if ($urandom_range(3) == 0) strb[BW-1:BW/2] = '0;
            push_pkt(s, p + 100, len, strb);
            total += int'(len);
        end
        vpct       = 80;
        rand_ready = 1'b1;
        seen = 0; sops = 0; eops = 0; cur = 0; in_pkt = 1'b0;
        for (int c = 0; c < 80000 && seen < total; c++) begin
            step();
            while (out_q.size() > 0) begin
                o = out_q.pop_front();
                seen++;
                src = int'(o.d[DW-1 -: 2]);
                n_checks++;
                if (src > 2 || expq[src].size() == 0) begin
                    $display("FAIL rand_word got %h want none from source %0d", o.d, src);
                end else begin
                    e = expq[src].pop_front();
                    if ({o.d, o.sop, o.eop, o.empty} !== {e.d, e.f, e.l, e.l && (e.s[BW-1:BW/2] == '0)})
                        $display("FAIL rand_word got %h/%b%b%b want %h/%b%b%b", o.d, o.sop, o.eop, o.empty,
                                 e.d, e.f, e.l, e.l && (e.s[BW-1:BW/2] == '0));
                    else n_pass++;
                end
                ok = o.sop ? !in_pkt : (in_pkt && cur == src);
                n_checks++; if (!ok) $display("FAIL rand_interleave got src %0d sop %b want open=%b src %0d",
                                              src, o.sop, in_pkt, cur); else n_pass++;
                if (o.sop) begin cur = src; in_pkt = 1'b1; sops++; end
                if (o.eop) begin in_pkt = 1'b0; eops++; end
            end
        end
        rand_ready   = 1'b0;
        vpct         = 100;
        tx_st_ready0 = 1'b1;
        n_checks++; if (seen != total) $display("FAIL rand_words got %0d want %0d", seen, total); else n_pass++;
        n_checks++; if (sops != 10000) $display("FAIL rand_sop_count got %0d want 10000", sops); else n_pass++;
        n_checks++; if (eops != 10000) $display("FAIL rand_eop_count got %0d want 10000", eops); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_rr_order();
        test_single_empty();
        test_stall();
        test_tvalid_gap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
